// File: rtl/cache_ctrl.sv
// Purpose: direct-mapped, write-through / no-write-allocate cache controller
//          that owns the tag array and sequences the line refill or word write.
// Latency: read hit completes in the request cycle; a read miss completes one
//          cycle after mem_ack; a write completes on the mem_ack cycle.
// Backpressure: the CPU holds cpu_req until cpu_ready; memory stalls the FSM
//          by withholding mem_ack.
//
// Ports:
//   clk, reset             clock; asynchronous active-high reset
//   cpu_req/we/addr/wdata  CPU access request (addr[1:0] ignored)
//   cpu_ready              access completes this cycle
//   refill/update/read     strobes to the cache data array
//   index_offset, wdata,   pass-through word index, store data and refill line
//   miss_mm_data             for the cache data array
//   mem_rd_req/wr_req      line read / word write request to memory
//   mem_addr, mem_wdata    memory address and store data
//   mem_rdata, mem_ack     refill line and one-cycle completion from memory
//   hit_cnt, miss_cnt      wrapping statistics counters
module cache_ctrl #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int LINE_WIDTH  = 128,
    parameter int INDEX_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cpu_req,
    input  logic                   cpu_we,
    input  logic [ADDR_WIDTH-1:0]  cpu_addr,
    input  logic [DATA_WIDTH-1:0]  cpu_wdata,
    output logic                   cpu_ready,
    output logic                   refill,
    output logic                   update,
    output logic                   read,
    output logic [INDEX_WIDTH+1:0] index_offset,
    output logic [DATA_WIDTH-1:0]  wdata,
    output logic [LINE_WIDTH-1:0]  miss_mm_data,
    output logic                   mem_rd_req,
    output logic                   mem_wr_req,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    output logic [DATA_WIDTH-1:0]  mem_wdata,
    input  logic [LINE_WIDTH-1:0]  mem_rdata,
    input  logic                   mem_ack,
    output logic [31:0]            hit_cnt,
    output logic [31:0]            miss_cnt
);

    localparam int TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH - 4;
    localparam int LINES     = 2 ** INDEX_WIDTH;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MEM_RD = 2'd1,
        MEM_WR = 2'd2
    } state_t;

    state_t state, next_state;

    logic [TAG_WIDTH-1:0]   tag_mem [LINES];
    logic [LINES-1:0]       valid;
    logic [INDEX_WIDTH-1:0] index;
    logic [TAG_WIDTH-1:0]   tag;
    logic                   hit;
    logic                   relook;   // this IDLE cycle is the re-lookup right after a refill
    logic                   hit_inc;
    logic                   miss_inc;

    assign index        = cpu_addr[INDEX_WIDTH+3:4];
    assign tag          = cpu_addr[ADDR_WIDTH-1:INDEX_WIDTH+4];
    assign hit          = cpu_req & valid[index] & (tag_mem[index] == tag);

    assign index_offset = cpu_addr[INDEX_WIDTH+3:2];
    assign wdata        = cpu_wdata;
    assign mem_wdata    = cpu_wdata;
    assign miss_mm_data = mem_rdata;

    always_comb begin
        next_state = state;
        cpu_ready  = 1'b0;
        refill     = 1'b0;
        update     = 1'b0;
        read       = 1'b0;
        mem_rd_req = 1'b0;
        mem_wr_req = 1'b0;
        mem_addr   = '0;
        hit_inc    = 1'b0;
        miss_inc   = 1'b0;
        case (state)
            IDLE: begin
                // mem_ack here is a stray and is deliberately ignored
                if (cpu_req) begin
                    if (cpu_we) begin
                        // write-through: every write goes to memory; stats taken on entry
                        next_state = MEM_WR;
                        hit_inc    = hit;
                        miss_inc   = ~hit;
                    end else if (hit) begin
                        read      = 1'b1;
                        cpu_ready = 1'b1;
                        hit_inc   = ~relook;
                    end else begin
                        next_state = MEM_RD;
                        miss_inc   = 1'b1;
                    end
                end
            end
            MEM_RD: begin
                mem_rd_req = 1'b1;
                mem_addr   = {tag, index, 4'b0000};
                if (mem_ack) begin
                    // an abandoned request still finishes the bus cycle but writes nothing
                    refill     = cpu_req;
                    next_state = IDLE;
                end
            end
            MEM_WR: begin
                mem_wr_req = 1'b1;
                // word-aligned address; masking keeps every address bit in use
                mem_addr   = cpu_addr & ~ADDR_WIDTH'(3);
                if (mem_ack) begin
                    cpu_ready  = 1'b1;
                    update     = hit;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            valid    <= '0;
            relook   <= 1'b0;
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            state  <= next_state;
            relook <= refill;
            if (refill)
                valid[index] <= 1'b1;
            if (hit_inc)
                hit_cnt <= hit_cnt + 32'd1;
            if (miss_inc)
                miss_cnt <= miss_cnt + 32'd1;
        end
    end

    // Tag storage needs no reset: the valid bits qualify every entry.
    always_ff @(posedge clk) begin
        if (refill)
            tag_mem[index] <= tag;
    end

endmodule
